ram_load_arbiter: RTL and testbench

//  Owns the single program/data RAM port of the 8-bit processor and shares it between two requesters:
//  the CPU datapath (fetch/execute accesses sequenced by the control unit) and a byte-wide program loader.

---
 rtl/proc_pkg.sv | 13 +
 rtl/load_addr_counter.sv | 22 ++
 rtl/ram_load_arbiter.sv | 103 ++++++++++
 tb/tb_ram_load_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants and arbiter state encoding for the 8-bit processor memory subsystem.
package proc_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 5;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/load_addr_counter.sv
// Loader write pointer: increments on each accepted byte, clear has priority.
module load_addr_counter #(
    parameter int unsigned ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram_load_arbiter.sv
// Shares the single RAM port between the CPU datapath and the byte-wide program loader.
module ram_load_arbiter #(
    parameter int unsigned DATA_W   = proc_pkg::DATA_W,
    parameter int unsigned ADDR_W   = proc_pkg::ADDR_W,
    parameter int unsigned LOAD_LEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import proc_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(LOAD_LEN - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ADDR_W-1:0] ptr;
    logic              beat;
    logic              ptr_clr;

    load_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (beat),
        .clr   (ptr_clr),
        .ptr   (ptr)
    );

    // State, completion pulse and read-valid registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RUN;
            ld_done    <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_done    <= (state_d == S_DONE);
            cpu_rvalid <= cpu_gnt & ~cpu_we;
        end
    end

    // Next state and RAM port muxing; the CPU only drives the port in S_RUN.
    always_comb begin
        state_d   = state_q;
        cpu_gnt   = 1'b0;
        cpu_stall = 1'b0;
        ld_ready  = 1'b0;
        ram_addr  = cpu_addr;
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        beat      = 1'b0;
        ptr_clr   = 1'b0;
        unique case (state_q)
            S_RUN: begin
                cpu_gnt = cpu_req;
                ram_we  = cpu_req & cpu_we;
                if (ld_start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cpu_stall = 1'b1;
                ld_ready  = 1'b1;
                beat      = ld_valid;
                ram_addr  = ptr;
                ram_wdata = ld_data;
                ram_we    = ld_valid;
                if (ld_valid && (ptr == LAST_PTR)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cpu_stall = 1'b1;
                ptr_clr   = 1'b1;
                state_d   = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign cpu_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Scoreboard bench for ram_load_arbiter: random CPU traffic and loader bursts against a RAM model.
module tb_ram_load_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_start, ld_valid, ld_ready, ld_done;
    logic [7:0] ld_data;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic [4:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata, ram_rdata;

    logic       b_ld_start, b_ld_valid, b_ld_ready, b_ld_done;
    logic [7:0] b_ld_data;
    logic       b_cpu_gnt, b_cpu_stall, b_cpu_rvalid;
    logic [7:0] b_cpu_rdata;
    logic [4:0] b_ram_addr;
    logic       b_ram_we;
    logic [7:0] b_ram_wdata, b_ram_rdata;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;
    typedef struct {
        int         cyc;
        logic [7:0] data;
    } rd_t;

    wr_t        wq[$];
    rd_t        rq[$];
    logic [7:0] mem[32];
    logic [7:0] b_mem[32];
    logic [7:0] ref_mem[32];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         done_seen = 0;
    int         exp_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_load_arbiter dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_load_arbiter #(.LOAD_LEN(4)) dut4 (
        .clk(clk), .reset(reset),
        .ld_start(b_ld_start), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
        .ld_ready(b_ld_ready), .ld_done(b_ld_done),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(5'd0), .cpu_wdata(8'd0),
        .cpu_gnt(b_cpu_gnt), .cpu_stall(b_cpu_stall), .cpu_rdata(b_cpu_rdata),
        .cpu_rvalid(b_cpu_rvalid),
        .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
    );

    // Synchronous RAM macros with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (b_ram_we) b_mem[b_ram_addr] <= b_ram_wdata;
        b_ram_rdata <= b_mem[b_ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write and every read return is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                check("missed_write", 32'(wq[0].addr), 32'hFFFF);
                void'(wq.pop_front());
            end
            if (ram_we) begin
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e.addr));
                    check("wr_data", 32'(ram_wdata), 32'(e.data));
                end else begin
                    check("unexpected_write", 32'(ram_we), 32'd0);
                end
            end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
                check("write_missing", 32'(ram_we), 32'd1);
                void'(wq.pop_front());
            end
            if (cpu_rvalid) begin
                if (rq.size() > 0) begin
                    rd_t r;
                    r = rq.pop_front();
                    check("rd_latency", 32'(cyc), 32'(r.cyc));
                    check("rd_data", 32'(cpu_rdata), 32'(r.data));
                end else begin
                    check("unexpected_rvalid", 32'(cpu_rvalid), 32'd0);
                end
            end
            if (ld_done) done_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [4:0] a, input logic [7:0] wd,
                         input logic st, input logic v, input logic [7:0] d);
        step();
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        ld_start  = st;
        ld_valid  = v;
        ld_data   = d;
    endtask

    // Reference behaviour of a granted CPU access issued in the current cycle.
    task automatic expect_cpu(input logic we, input logic [4:0] a, input logic [7:0] wd);
        if (we) begin
            wq.push_back('{cyc, a, wd});
            ref_mem[a] = wd;
        end else begin
            rq.push_back('{cyc + 1, ref_mem[a]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 8'd0);
            @(negedge clk);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [4:0] a, input logic [7:0] wd);
        drive(1'b1, we, a, wd, 1'b0, 1'b0, 8'd0);
        expect_cpu(we, a, wd);
        @(negedge clk);
        check("cpu_gnt_run", 32'(cpu_gnt), 32'd1);
        check("cpu_stall_run", 32'(cpu_stall), 32'd0);
    endtask

    task automatic readback_all();
        for (int i = 0; i < 32; i++) cpu_access(1'b0, 5'(i), 8'd0);
        idle(2);
    endtask

    // One loader burst; optional CPU request held throughout, optional reset after 'beats' bytes.
    task automatic load_burst(input int beats, input bit gappy, input bit hold, input logic hwe,
                              input logic [4:0] ha, input logic [7:0] hwd, input bit abort);
        int         k;
        bit         v;
        logic [7:0] b;
        drive(hold, hwe, ha, hwd, 1'b1, 1'b0, 8'd0);
        if (hold) expect_cpu(hwe, ha, hwd);
        @(negedge clk);
        check("start_gnt", 32'(cpu_gnt), 32'(hold));
        check("start_ready", 32'(ld_ready), 32'd0);
        k = 0;
        while (k < beats) begin
            v = gappy ? ($urandom_range(0, 2) == 0) : 1'b1;
            b = gappy ? 8'($urandom) : (8'(k) ^ 8'hFF);
            drive(hold, hwe, ha, hwd, 1'b0, v, b);
            if (v) begin
                wq.push_back('{cyc, 5'(k), b});
                ref_mem[k] = b;
                k++;
            end
            @(negedge clk);
            check("load_ready", 32'(ld_ready), 32'd1);
            check("load_stall", 32'(cpu_stall), 32'd1);
            check("load_gnt", 32'(cpu_gnt), 32'd0);
        end
        if (abort) begin
            step();
            reset     = 1'b1;
            cpu_req   = 1'b0;
            ld_valid  = 1'b0;
            @(negedge clk);
            check("abort_ready", 32'(ld_ready), 32'd0);
            check("abort_stall", 32'(cpu_stall), 32'd0);
            check("abort_done", 32'(ld_done), 32'd0);
            step();
            reset = 1'b0;
            return;
        end
        drive(hold, hwe, ha, hwd, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        check("done_pulse", 32'(ld_done), 32'd1);
        check("done_stall", 32'(cpu_stall), 32'd1);
        check("done_gnt", 32'(cpu_gnt), 32'd0);
        check("done_ready", 32'(ld_ready), 32'd0);
        exp_done++;
        drive(hold, hwe, ha, hwd, 1'b0, 1'b0, 8'd0);
        if (hold) expect_cpu(hwe, ha, hwd);
        @(negedge clk);
        check("after_done", 32'(ld_done), 32'd0);
        check("after_stall", 32'(cpu_stall), 32'd0);
        check("after_gnt", 32'(cpu_gnt), 32'(hold));
    endtask

    // LOAD_LEN=4 instance with ld_start held high across two bursts.
    task automatic short_bursts();
        logic [7:0] d;
        step();
        b_ld_start = 1'b1;
        b_ld_valid = 1'b1;
        b_ld_data  = 8'hEE;
        @(negedge clk);
        check("b_ready_run", 32'(b_ld_ready), 32'd0);
        check("b_we_run", 32'(b_ram_we), 32'd0);
        for (int burst = 0; burst < 2; burst++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                d = 8'($urandom);
                b_ld_data = d;
                @(negedge clk);
                check("b_ready", 32'(b_ld_ready), 32'd1);
                check("b_we", 32'(b_ram_we), 32'd1);
                check("b_addr", 32'(b_ram_addr), 32'(i));
                check("b_wdata", 32'(b_ram_wdata), 32'(d));
            end
            step();
            if (burst == 1) b_ld_start = 1'b0;
            @(negedge clk);
            check("b_done", 32'(b_ld_done), 32'd1);
            check("b_done_we", 32'(b_ram_we), 32'd0);
            check("b_done_stall", 32'(b_cpu_stall), 32'd1);
            step();
            @(negedge clk);
            check("b_run_done", 32'(b_ld_done), 32'd0);
            check("b_run_ready", 32'(b_ld_ready), 32'd0);
            check("b_run_stall", 32'(b_cpu_stall), 32'd0);
        end
        step();
        @(negedge clk);
        check("b_no_restart", 32'(b_ld_ready), 32'd0);
        b_ld_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 8'd0;
            b_mem[i]   = 8'd0;
            ref_mem[i] = 8'd0;
        end
        reset = 1'b1;
        {ld_start, ld_valid, cpu_req, cpu_we} = 4'b0;
        ld_data = 8'd0; cpu_addr = 5'd0; cpu_wdata = 8'd0;
        {b_ld_start, b_ld_valid} = 2'b0;
        b_ld_data = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        step();
        reset = 1'b0;
        idle(1);

        cpu_access(1'b1, 5'd5, 8'h5A);
        cpu_access(1'b0, 5'd5, 8'd0);
        idle(2);

        for (int i = 0; i < 30; i++) begin
            cpu_access(1'($urandom), 5'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        load_burst(32, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        readback_all();

        load_burst(32, 1'b1, 1'b1, 1'b1, 5'($urandom), 8'($urandom), 1'b0);
        idle(1);

        load_burst(32, 1'b1, 1'b1, 1'b0, 5'd3, 8'd0, 1'b0);
        idle(2);
        readback_all();

        load_burst(10, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
        idle(3);
        check("abort_no_done", 32'(done_seen), 32'(exp_done));
        readback_all();
        load_burst(32, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        readback_all();

        short_bursts();
        idle(3);

        check("ld_done_count", 32'(done_seen), 32'(exp_done));
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
